// File: rtl/dense_result_drain.sv
// dense_result_drain: buffers MAC result pairs in a FIFO and
// serialises them onto one ready/valid word stream, lane 1 first.
module dense_result_drain #(
  parameter int DW    = 64,
  parameter int DEPTH = 16,
  parameter int ROWS  = 280,
  parameter int RW    = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              datain1,
  input  logic [DW-1:0]              datain2,
  input  logic                       valid_in,
  output logic [DW-1:0]              dout,
  output logic                       dout_lane,
  output logic [RW-1:0]              dout_row,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic                       frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LANE1,
    LANE2
  } state_t;

  state_t state;

  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  logic [RW-1:0] memr [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] nx_ptr;
  logic [RW-1:0] row_ctr;

  logic          pop_now;
  logic          push_ok;
  logic          more;
  logic          bypass;
  logic [DW-1:0] next_d1;
  logic [RW-1:0] next_row;

  assign pop_now = (state == LANE2) & dout_ready;
  assign push_ok = valid_in & ((occupancy < FULL) | pop_now);
  assign nx_ptr  = rd_ptr + AW'(1);

  // After popping the last stored pair, a pair pushed on the same
  // edge becomes the new head; forward it so no bubble appears.
  assign bypass   = (occupancy == ONE);
  assign more     = (occupancy > ONE) | push_ok;
  assign next_d1  = bypass ? datain1 : mem1[nx_ptr];
  assign next_row = bypass ? row_ctr : memr[nx_ptr];

  // Pair storage, written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem1[wr_ptr] <= datain1;
      mem2[wr_ptr] <= datain2;
      memr[wr_ptr] <= row_ctr;
    end
  end

  // Pointers, occupancy, row tagging and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      row_ctr    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push_ok & (row_ctr == LAST_ROW);
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_now) begin
        rd_ptr <= nx_ptr;
      end
      if (push_ok & !pop_now) begin
        occupancy <= occupancy + ONE;
      end else if (!push_ok & pop_now) begin
        occupancy <= occupancy - ONE;
      end
      if (valid_in & !push_ok) begin
        overflow <= 1'b1;
      end
      // Tags follow the accumulator even when a pair is dropped
      if (valid_in) begin
        row_ctr <= (row_ctr == LAST_ROW) ? '0 : row_ctr + RW'(1);
      end
    end
  end

  // Output serialiser with registered word, lane, row and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dout       <= '0;
      dout_lane  <= 1'b0;
      dout_row   <= '0;
      dout_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (occupancy != '0) begin
            state <= LANE1;
          end
        end
        LANE1: begin
          if (!dout_valid) begin
            dout       <= mem1[rd_ptr];
            dout_lane  <= 1'b0;
            dout_row   <= memr[rd_ptr];
            dout_valid <= 1'b1;
          end else if (dout_ready) begin
            dout      <= mem2[rd_ptr];
            dout_lane <= 1'b1;
            state     <= LANE2;
          end
        end
        LANE2: begin
          if (dout_ready) begin
            if (more) begin
              dout      <= next_d1;
              dout_lane <= 1'b0;
              dout_row  <= next_row;
              state     <= LANE1;
            end else begin
              dout_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_result_drain.sv
// tb_dense_result_drain: directed tables, corner sequences and a
// randomized run against a queue-based reference of the word stream.
module tb_dense_result_drain;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int ROWS  = 280;
  localparam int RW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] datain1;
  logic [DW-1:0] datain2;
  logic          valid_in;
  logic [DW-1:0] dout;
  logic          dout_lane;
  logic [RW-1:0] dout_row;
  logic          dout_valid;
  logic          dout_ready;
  logic [4:0]    occupancy;
  logic          overflow;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  dense_result_drain #(
    .DW(DW), .DEPTH(DEPTH), .ROWS(ROWS), .RW(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .datain1(datain1),
    .datain2(datain2),
    .valid_in(valid_in),
    .dout(dout),
    .dout_lane(dout_lane),
    .dout_row(dout_row),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .occupancy(occupancy),
    .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] w1;
    logic [63:0] w2;
    int          row;
  } vec_t;

  typedef struct {
    logic [63:0] w;
    logic        lane;
    int          row;
  } word_t;

  word_t q[$];
  int    occ_m;
  int    row_m;
  logic  ovf_m;
  logic  fd_m;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid_in = 1'b0;
    dout_ready = 1'b0;
    datain1 = '0;
    datain2 = '0;
    tick;
    tick;
    #2 rst = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      valid_in = 1'b1;
      datain1 = 64'(base + k);
      datain2 = 64'(base + k + 1000);
      tick;
    end
    valid_in = 1'b0;
  endtask

  // One randomized cycle: compare, advance the reference, clock
  task automatic rand_cycle(input logic v, input logic r);
    logic        xfer;
    logic        l2pop;
    logic        pok;
    logic [63:0] a;
    logic [63:0] b;
    chk("rnd_occ", occupancy, 64'(occ_m));
    chk("rnd_ovf", overflow, 64'(ovf_m));
    chk("rnd_fd", frame_done, 64'(fd_m));
    xfer = dout_valid & r;
    l2pop = 1'b0;
    if (dout_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_spurious: got valid word %0h expected none",
                 dout);
      end else begin
        chk("rnd_word", dout, q[0].w);
        chk("rnd_lane", dout_lane, 64'(q[0].lane));
        chk("rnd_row", dout_row, 64'(q[0].row));
        if (xfer) begin
          l2pop = q[0].lane;
          void'(q.pop_front());
        end
      end
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    pok = v && (occ_m < DEPTH || l2pop);
    if (pok) begin
      q.push_back('{w: a, lane: 1'b0, row: row_m});
      q.push_back('{w: b, lane: 1'b1, row: row_m});
      occ_m++;
    end
    if (l2pop) occ_m--;
    fd_m = pok && (row_m == ROWS - 1);
    if (v && !pok) ovf_m = 1'b1;
    if (v) row_m = (row_m + 1) % ROWS;
    valid_in = v;
    dout_ready = r;
    datain1 = a;
    datain2 = b;
    tick;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{64'h11, 64'h22, 64'h11, 64'h22, 0};
    tbl[1] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[2] = '{64'hAAAA_AAAA_5555_5555, 64'h5555_5555_AAAA_AAAA,
               64'hAAAA_AAAA_5555_5555, 64'h5555_5555_AAAA_AAAA, 2};
    tbl[3] = '{64'h8000_0000_0000_0001, 64'h1,
               64'h8000_0000_0000_0001, 64'h1, 3};
    tbl[4] = '{64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEED_F00D,
               64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEED_F00D, 4};
    tbl[5] = '{64'h7, 64'h7, 64'h7, 64'h7, 5};

    do_reset;
    chk("rst_valid", dout_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_lane", dout_lane, 0);
    chk("rst_row", dout_row, 0);

    // Single pairs from the table, sink always ready
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      datain1 = tbl[i].d1;
      datain2 = tbl[i].d2;
      tick;
      valid_in = 1'b0;
      chk("tbl_occ1", occupancy, 1);
      tick;
      chk("tbl_lat", dout_valid, 0);
      tick;
      chk("tbl_v1", dout_valid, 1);
      chk("tbl_w1", dout, tbl[i].w1);
      chk("tbl_l1", dout_lane, 0);
      chk("tbl_r1", dout_row, 64'(tbl[i].row));
      tick;
      chk("tbl_v2", dout_valid, 1);
      chk("tbl_w2", dout, tbl[i].w2);
      chk("tbl_l2", dout_lane, 1);
      chk("tbl_r2", dout_row, 64'(tbl[i].row));
      tick;
      chk("tbl_idle", dout_valid, 0);
      chk("tbl_occ0", occupancy, 0);
    end
    chk("tbl_ovf", overflow, 0);

    // Back-pressure: three pairs, sink stalled then released
    do_reset;
    push_n(3, 100);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", dout_valid, 1);
      chk("bp_hold", dout, 100);
      chk("bp_lane", dout_lane, 0);
      tick;
    end
    chk("bp_occ", occupancy, 3);
    dout_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_dv", dout_valid, 1);
      chk("bp_word", dout, 64'((k % 2) ? 1100 + k / 2 : 100 + k / 2));
      chk("bp_dl", dout_lane, 64'(k % 2));
      chk("bp_row", dout_row, 64'(k / 2));
      tick;
    end
    chk("bp_end_valid", dout_valid, 0);
    chk("bp_end_occ", occupancy, 0);

    // Overflow: 17 pairs into a 16-deep FIFO with the sink stalled
    do_reset;
    push_n(16, 0);
    chk("ov_occ16", occupancy, 16);
    chk("ov_pre", overflow, 0);
    push_n(1, 16);
    chk("ov_occ", occupancy, 16);
    chk("ov_flag", overflow, 1);
    dout_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chk("ov_dv", dout_valid, 1);
      chk("ov_word", dout, 64'((k % 2) ? 1000 + k / 2 : k / 2));
      chk("ov_row", dout_row, 64'(k / 2));
      tick;
    end
    chk("ov_empty", occupancy, 0);
    push_n(1, 55);
    tick;
    tick;
    chk("ov_next_dv", dout_valid, 1);
    chk("ov_next_row", dout_row, 17);
    chk("ov_next_w", dout, 55);
    chk("ov_sticky", overflow, 1);

    // Full FIFO, push coinciding with a lane-2 pop
    do_reset;
    push_n(16, 0);
    dout_ready = 1'b1;
    tick;
    chk("fp_lane2", dout_lane, 1);
    chk("fp_w", dout, 1000);
    valid_in = 1'b1;
    datain1 = 64'd16;
    datain2 = 64'd1016;
    tick;
    valid_in = 1'b0;
    chk("fp_occ", occupancy, 16);
    chk("fp_ovf", overflow, 0);
    for (int k = 2; k < 34; k++) begin
      chk("fp_dv", dout_valid, 1);
      chk("fp_word", dout, 64'((k % 2) ? 1000 + k / 2 : k / 2));
      chk("fp_row", dout_row, 64'(k / 2));
      tick;
    end
    chk("fp_empty", occupancy, 0);
    chk("fp_ovf_end", overflow, 0);

    // Frame wrap: 281 pairs at the sustained rate
    do_reset;
    dout_ready = 1'b1;
    begin
      int pushes = 0;
      int seen = 0;
      int fdc = 0;
      for (int c = 0; c < 600; c++) begin
        logic v;
        v = (c % 2 == 0) && (pushes < 281);
        valid_in = v;
        datain1 = 64'(pushes);
        datain2 = 64'(pushes + 5000);
        tick;
        if (v) pushes++;
        if (frame_done) begin
          fdc++;
          chk("fw_fd_when", 64'(pushes), 280);
        end
        if (dout_valid && !dout_lane) begin
          chk("fw_data", dout, 64'(seen));
          if (seen == 279) chk("fw_row279", dout_row, 279);
          if (seen == 280) chk("fw_row_wrap", dout_row, 0);
          seen++;
        end
      end
      valid_in = 1'b0;
      chk("fw_fd_count", 64'(fdc), 1);
      chk("fw_pairs", 64'(seen), 281);
      chk("fw_ovf", overflow, 0);
    end

    // Async reset while holding five pairs in lane 2
    do_reset;
    push_n(5, 300);
    dout_ready = 1'b1;
    tick;
    dout_ready = 1'b0;
    chk("ar_occ5", occupancy, 5);
    chk("ar_lane2", dout_lane, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", dout_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_ovf", overflow, 0);
    #1 rst = 1'b0;
    tick;
    dout_ready = 1'b1;
    push_n(1, 77);
    tick;
    tick;
    chk("ar_new_dv", dout_valid, 1);
    chk("ar_new_row", dout_row, 0);
    chk("ar_new_w", dout, 77);

    // Randomized traffic against the reference queue
    do_reset;
    q.delete();
    occ_m = 0;
    row_m = 0;
    ovf_m = 1'b0;
    fd_m = 1'b0;
    for (int ph = 0; ph < 8; ph++) begin
      int rp = $urandom_range(20, 100);
      int vp = $urandom_range(10, 90);
      for (int c = 0; c < 400; c++) begin
        rand_cycle(($urandom_range(99) < vp), ($urandom_range(99) < rp));
      end
    end
    for (int c = 0; c < 80; c++) begin
      rand_cycle(1'b0, 1'b1);
    end
    chk("rnd_drained", 64'(q.size()), 0);
    chk("rnd_occ_end", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
